// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing.
//   ROB_DEPTH / ROB_ADDR_WIDTH : default ROB geometry (power-of-two depth)
//   rob_addr_t                 : ROB tag carried in reservation-station entries
//   rob_entry_t                : one in-flight uop record for the default PC width
package rob_pkg;

   localparam int ROB_DEPTH          = 16;
   localparam int ROB_ADDR_WIDTH     = $clog2(ROB_DEPTH);
   localparam int QU_PC_WIDTH        = 32;
   localparam int PHY_RF_ADDR_WIDTH  = 6;
   localparam int ARCH_RF_ADDR_WIDTH = 5;

   typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;

   typedef struct packed {
      logic                          valid;
      logic                          done;
      logic                          exc;
      logic                          has_rd;
      logic [ARCH_RF_ADDR_WIDTH-1:0] arch_rd;
      logic [PHY_RF_ADDR_WIDTH-1:0]  phy_rd;
      logic [PHY_RF_ADDR_WIDTH-1:0]  old_phy_rd;
      logic [QU_PC_WIDTH-1:0]        pc;
   } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight uops.
//   alloc_*   : in-order allocation from rename; tail_ptr is the tag handed out
//   full/empty: occupancy, from registered pointers only
//   cmpl_*    : out-of-order completion (done/exc) by ROB tag
//   commit_*  : in-order retirement of the head entry (combinational)
//   flush*    : excepting head; squashes the whole ROB at the edge
//   clk, rst  : rising-edge clock, asynchronous active-low reset
module rob
   import rob_pkg::*;
#(
   parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
   parameter int PC_WIDTH  = rob_pkg::QU_PC_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alloc_en,
   input  logic                          alloc_has_rd,
   input  logic [ARCH_RF_ADDR_WIDTH-1:0] alloc_arch_rd,
   input  logic [PHY_RF_ADDR_WIDTH-1:0]  alloc_phy_rd,
   input  logic [PHY_RF_ADDR_WIDTH-1:0]  alloc_old_phy_rd,
   input  logic [PC_WIDTH-1:0]           alloc_pc,
   output logic [$clog2(ROB_DEPTH)-1:0]  tail_ptr,
   output logic                          full,
   output logic                          empty,
   input  logic                          cmpl_en,
   input  logic [$clog2(ROB_DEPTH)-1:0]  cmpl_addr,
   input  logic                          cmpl_exc,
   output logic                          commit_en,
   output logic                          commit_has_rd,
   output logic [ARCH_RF_ADDR_WIDTH-1:0] commit_arch_rd,
   output logic [PHY_RF_ADDR_WIDTH-1:0]  commit_phy_rd,
   output logic [PHY_RF_ADDR_WIDTH-1:0]  commit_old_phy_rd,
   output logic                          flush,
   output logic [PC_WIDTH-1:0]           flush_pc
);

   localparam int AW = $clog2(ROB_DEPTH);

   // Same layout as rob_entry_t, but with the PC width of this instance.
   typedef struct packed {
      logic                          valid;
      logic                          done;
      logic                          exc;
      logic                          has_rd;
      logic [ARCH_RF_ADDR_WIDTH-1:0] arch_rd;
      logic [PHY_RF_ADDR_WIDTH-1:0]  phy_rd;
      logic [PHY_RF_ADDR_WIDTH-1:0]  old_phy_rd;
      logic [PC_WIDTH-1:0]           pc;
   } entry_t;

   entry_t        ent_q [ROB_DEPTH];
   entry_t        ent_d [ROB_DEPTH];
   // Pointers carry one extra MSB (wrap bit) to tell full from empty.
   logic [AW:0]   head_q, head_d;
   logic [AW:0]   tail_q, tail_d;
   logic [AW-1:0] head_idx, tail_idx;
   entry_t        head_ent;

   assign head_idx = head_q[AW-1:0];
   assign tail_idx = tail_q[AW-1:0];
   assign head_ent = ent_q[head_idx];

   assign tail_ptr = tail_idx;
   assign empty    = (head_q == tail_q);
   assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

   assign commit_en         = head_ent.valid & head_ent.done & ~head_ent.exc;
   assign commit_has_rd     = head_ent.has_rd;
   assign commit_arch_rd    = head_ent.arch_rd;
   assign commit_phy_rd     = head_ent.phy_rd;
   assign commit_old_phy_rd = head_ent.old_phy_rd;
   assign flush             = head_ent.valid & head_ent.done & head_ent.exc;
   assign flush_pc          = head_ent.pc;

   always_comb begin
      ent_d  = ent_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         // Squash everything; same-cycle alloc and completion are discarded.
         for (int i = 0; i < ROB_DEPTH; i++) ent_d[i].valid = 1'b0;
         head_d = '0;
         tail_d = '0;
      end else begin
         if (commit_en) begin
            ent_d[head_idx].valid = 1'b0;
            head_d                = head_q + 1'b1;
         end
         if (cmpl_en && ent_q[cmpl_addr].valid) begin
            ent_d[cmpl_addr].done = 1'b1;
            ent_d[cmpl_addr].exc  = cmpl_exc;
         end
         // full is from registered state, so a same-cycle commit cannot
         // make room for this alloc.
         if (alloc_en && !full) begin
            ent_d[tail_idx].valid      = 1'b1;
            ent_d[tail_idx].done       = 1'b0;
            ent_d[tail_idx].exc        = 1'b0;
            ent_d[tail_idx].has_rd     = alloc_has_rd;
            ent_d[tail_idx].arch_rd    = alloc_arch_rd;
            ent_d[tail_idx].phy_rd     = alloc_phy_rd;
            ent_d[tail_idx].old_phy_rd = alloc_old_phy_rd;
            ent_d[tail_idx].pc         = alloc_pc;
            tail_d                     = tail_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= ent_d[i];
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule
